// File: rtl/led_trail_pwm.sv
// -----------------------------------------------------------------------------
// led_trail_pwm
//
// Output stage for the KITT sweep. Each of the eight LEDs jumps to full
// brightness while its pattern bit is active and then fades linearly, one
// DECAY_STEP per PWM frame, once the bit drops. Each LED is driven by
// per-LED PWM, and this block sets the output polarity at the pins.
//
// Ports
//   clk_i      system clock
//   rstn_i     asynchronous, active-low reset
//   enable_i   synchronous enable; low blanks every LED and restarts timing
//   display_i  8-bit LED pattern, active level set by IN_POLARITY
//   led_o      registered LED drive, active level set by OUT_POLARITY
//   frame_o    one-cycle registered pulse at each PWM frame start
// -----------------------------------------------------------------------------
module led_trail_pwm #(
  parameter int   CLK_IN_MHZ   = 125,
  parameter int   FRAME_HZ     = 500,
  parameter int   PWM_BITS     = 8,
  parameter int   DECAY_STEP   = 4,
  parameter logic IN_POLARITY  = 1'b0,
  parameter logic OUT_POLARITY = 1'b0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       enable_i,
  input  logic [7:0] display_i,
  output logic [7:0] led_o,
  output logic       frame_o
);

  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

`ifdef SIM
  localparam bit SIM_MODE = 1'b1;
`else
  localparam bit SIM_MODE = 1'b0;
`endif

  localparam longint HZ_IN    = longint'(CLK_IN_MHZ) * longint'(1000000);
  localparam longint DEN      = longint'(FRAME_HZ) << PWM_BITS;
  localparam longint DIV_CALC = HZ_IN / DEN;
  // A divider of 1 degenerates the prescaler into a tick on every cycle.
  localparam int     PWM_DIV  = (SIM_MODE || DIV_CALC <= 1) ? 1 : int'(DIV_CALC);
  localparam int     PRE_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
  localparam logic [7:0] LED_OFF = OUT_POLARITY ? 8'h00 : 8'hFF;

  // Linear fade that stops at zero instead of wrapping.
  function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] b);
    return (b > STEP) ? (b - STEP) : '0;
  endfunction

  logic [PRE_W-1:0]    r_presc;
  logic [PWM_BITS-1:0] r_pwm;
  logic                w_tick;
  logic                w_fb;

  assign w_tick = (r_presc == PRE_LAST);
  assign w_fb   = w_tick && (r_pwm == MAX);

  // ---- timing: prescaler and PWM phase counter ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_presc <= '0;
      r_pwm   <= '0;
    end else if (!enable_i) begin
      r_presc <= '0;
      r_pwm   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_pwm <= r_pwm + 1'b1;
      end
    end
  end

  // ---- stage p0: pattern normalised to active-high ----
  logic [7:0] r_act_p0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_act_p0 <= '0;
    end else begin
      r_act_p0 <= IN_POLARITY ? display_i : ~display_i;
    end
  end

  // ---- stage p1: brightness, updated only at frame boundaries ----
  // Holding brightness for the whole frame keeps the duty glitch-free.
  logic [PWM_BITS-1:0] r_bright_p1 [8];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 8; i++) begin
        r_bright_p1[i] <= '0;
      end
    end else if (!enable_i) begin
      for (int i = 0; i < 8; i++) begin
        r_bright_p1[i] <= '0;
      end
    end else if (w_fb) begin
      for (int i = 0; i < 8; i++) begin
        // An active bit reloads full brightness even if it would also decay.
        r_bright_p1[i] <= r_act_p0[i] ? MAX : sat_dec(r_bright_p1[i]);
      end
    end
  end

  // ---- stage p2: PWM compare and registered pin drive ----
  logic [7:0] w_on;

  always_comb begin
    w_on = '0;
    for (int i = 0; i < 8; i++) begin
      // Full scale is forced on so MAX really means 100 % duty.
      w_on[i] = (r_bright_p1[i] == MAX) || (r_pwm < r_bright_p1[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      led_o   <= LED_OFF;
      frame_o <= 1'b0;
    end else if (!enable_i) begin
      led_o   <= LED_OFF;
      frame_o <= 1'b0;
    end else begin
      led_o   <= OUT_POLARITY ? w_on : ~w_on;
      frame_o <= w_fb;
    end
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_trail_pwm
//
// Bench for led_trail_pwm with 4-bit PWM (16-cycle frames), DECAY_STEP 4 and
// both polarities active-high. The clock and frame rates are chosen so the
// prescaler divides by one. A frame-level brightness model pushes the expected
// duty of each LED when a pattern is driven. The entry is popped and checked
// sample by sample against the following output frame.
// -----------------------------------------------------------------------------
module tb_led_trail_pwm;

  typedef logic [7:0][4:0] exp_t;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       enable_i;
  logic [7:0] display_i;
  logic [7:0] led_o;
  logic       frame_o;

  int   checks = 0;
  int   errors = 0;
  int   cnt     [8];
  int   b_model [8];
  exp_t q [$];

  always #5 clk_i = ~clk_i;

  led_trail_pwm #(
    .CLK_IN_MHZ  (1),
    .FRAME_HZ    (62500),
    .PWM_BITS    (4),
    .DECAY_STEP  (4),
    .IN_POLARITY (1'b1),
    .OUT_POLARITY(1'b1)
  ) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .enable_i (enable_i),
    .display_i(display_i),
    .led_o    (led_o),
    .frame_o  (frame_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Frame-level brightness model: apply the pattern seen at a boundary and
  // queue the duty (in counts of 16) the next output frame must show.
  task automatic apply_pattern(input logic [7:0] pat);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (pat[i]) b_model[i] = 15;
      else        b_model[i] = (b_model[i] > 4) ? b_model[i] - 4 : 0;
      e[i] = (b_model[i] == 15) ? 5'd16 : 5'(b_model[i]);
    end
    q.push_back(e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) b_model[i] = 0;
    q.delete();
  endtask

  // Waits (bounded) for the next frame_o pulse; n is the negedge count.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (frame_o !== 1'b1 && n < 40);
  endtask

  // Called at the negedge where frame_o is seen; samples the 16 cycles of
  // the output frame that follows and ends on the next frame_o negedge.
  task automatic measure_window(input bit drop_en, input logic [7:0] drop_pat);
    exp_t       e;
    logic [7:0] exp_v;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty led_o=%h expected=<queued frame>", led_o);
      e = '0;
    end else begin
      e = q.pop_front();
    end
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_i);
      for (int i = 0; i < 8; i++) exp_v[i] = (k < int'(e[i]));
      checks++;
      if (led_o !== exp_v) begin
        errors++;
        $display("FAIL pwm_sample k=%0d led_o=%h expected=%h", k, led_o, exp_v);
      end
      for (int i = 0; i < 8; i++) if (led_o[i] === 1'b1) cnt[i]++;
      if (drop_en && k == 14) display_i = drop_pat;
    end
    checks++;
    if (frame_o !== 1'b1) begin
      errors++;
      $display("FAIL frame_period frame_o=%b expected=1", frame_o);
    end
  endtask

  task automatic step(input logic [7:0] pat, input bit drop_en, input logic [7:0] drop_pat);
    display_i = pat;
    apply_pattern(pat);
    measure_window(drop_en, drop_pat);
  endtask

  task automatic test_reset();
    int n;
    rstn_i    = 1'b1;
    enable_i  = 1'b1;
    display_i = 8'hFF;
    #2 rstn_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      checks++;
      if (led_o !== 8'h00 || frame_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold led_o=%h frame_o=%b expected=00/0", led_o, frame_o);
      end
    end
    rstn_i = 1'b1;
    clear_model();
    wait_frame(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL reset_first_frame cycles=%0d expected=16", n);
    end
    for (int r = 0; r < 2; r++) begin
      wait_frame(n);
      checks++;
      if (n != 16) begin
        errors++;
        $display("FAIL frame_gap cycles=%0d expected=16", n);
      end
    end
    // Every boundary so far latched an all-active pattern.
    apply_pattern(8'hFF);
  endtask

  task automatic test_steady_on();
    for (int s = 0; s < 5; s++) step(8'h01, 1'b0, 8'h00);
    checks++;
    if (cnt[0] != 16) begin
      errors++;
      $display("FAIL steady_bit0 duty=%0d expected=16", cnt[0]);
    end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (cnt[i] != 0) begin
        errors++;
        $display("FAIL steady_other bit=%0d duty=%0d expected=0", i, cnt[i]);
      end
    end
  endtask

  task automatic test_decay();
    int exp_d [5] = '{16, 11, 7, 3, 0};
    for (int s = 0; s < 5; s++) begin
      step(8'h00, 1'b0, 8'h00);
      checks++;
      if (cnt[0] != exp_d[s]) begin
        errors++;
        $display("FAIL decay frame=%0d duty=%0d expected=%0d", s, cnt[0], exp_d[s]);
      end
    end
  endtask

  task automatic test_retrigger();
    step(8'h01, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h00);
    // Bit held for one frame, released the cycle before the boundary.
    step(8'h01, 1'b1, 8'h00);
    checks++;
    if (cnt[0] != 7) begin
      errors++;
      $display("FAIL retrigger_before duty=%0d expected=7", cnt[0]);
    end
    step(8'h00, 1'b0, 8'h00);
    checks++;
    if (cnt[0] != 16) begin
      errors++;
      $display("FAIL retrigger_full duty=%0d expected=16", cnt[0]);
    end
    step(8'h00, 1'b0, 8'h00);
    checks++;
    if (cnt[0] != 11) begin
      errors++;
      $display("FAIL retrigger_decay duty=%0d expected=11", cnt[0]);
    end
  endtask

  task automatic test_sweep();
    int exp_s [8] = '{0, 0, 0, 0, 3, 7, 11, 16};
    for (int s = 0; s < 4; s++) step(8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(8'(1 << i), 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cnt[i] != exp_s[i]) begin
        errors++;
        $display("FAIL sweep_trail bit=%0d duty=%0d expected=%0d", i, cnt[i], exp_s[i]);
      end
    end
  endtask

  task automatic check_restart(input string tag);
    int n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    do begin
      @(negedge clk_i);
      n++;
      if (led_o !== 8'h00) bad = 1'b1;
    end while (frame_o !== 1'b1 && n < 40);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL %s_first_frame cycles=%0d expected=16", tag, n);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_dark led_o=nonzero before first frame expected=00", tag);
    end
    @(negedge clk_i);
    checks++;
    if (led_o !== 8'hFF) begin
      errors++;
      $display("FAIL %s_relight led_o=%h expected=ff", tag, led_o);
    end
  endtask

  task automatic test_enable_reset();
    step(8'hFF, 1'b0, 8'h00);
    step(8'hFF, 1'b0, 8'h00);
    q.delete();
    for (int k = 0; k < 5; k++) @(negedge clk_i);
    checks++;
    if (led_o !== 8'hFF) begin
      errors++;
      $display("FAIL pre_disable led_o=%h expected=ff", led_o);
    end
    enable_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      checks++;
      if (led_o !== 8'h00 || frame_o !== 1'b0) begin
        errors++;
        $display("FAIL disabled led_o=%h frame_o=%b expected=00/0", led_o, frame_o);
      end
    end
    enable_i = 1'b1;
    check_restart("enable");
    for (int k = 0; k < 3; k++) @(negedge clk_i);
    #1 rstn_i = 1'b0;
    #1;
    checks++;
    if (led_o !== 8'h00 || frame_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset led_o=%h frame_o=%b expected=00/0", led_o, frame_o);
    end
    #1 rstn_i = 1'b1;
    check_restart("reset");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      cnt[i]     = 0;
      b_model[i] = 0;
    end
    test_reset();
    test_steady_on();
    test_decay();
    test_retrigger();
    test_sweep();
    test_enable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
